instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, word-aligned PC loaded at reset.
REQ-002 SHALL have port Clock  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 SHALL have port nReset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port IAddr  output  32  instruction memory request address, always equal to current PC.
REQ-005 SHALL have port IReq  output  1  request valid; the request is accepted on a cycle where IReq and IReady are both high.
REQ-006 SHALL have port IReady  input  1  memory can accept a request this cycle.
REQ-007 SHALL have port IValid  input  1  read response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-008 SHALL have port IData  input  32  read response data.
REQ-009 SHALL have port Redirect  input  1  taken branch or jump; flushes fetch.
REQ-010 SHALL have port Target  input  32  redirect address; bits [1:0] ignored and forced to 0.
REQ-011 SHALL have port DecStall  input  1  decode cannot accept an instruction this cycle.
REQ-012 SHALL have port Instruction  output  32  instruction presented to decode.
REQ-013 SHALL have port InstrAddrOut  output  32  byte address of Instruction.
REQ-014 SHALL have port InstrValid  output  1  Instruction and InstrAddrOut are valid.

Function
REQ-015 SHALL hold a 2-entry in-order instruction buffer of {address, data} pairs; the head drives Instruction/InstrAddrOut; InstrValid = buffer not empty.
REQ-016 SHALL treat the head as consumed on a cycle where InstrValid=1 and DecStall=0.
REQ-017 SHALL assert IReq only when in-flight requests + buffered entries < 2 and Redirect=0; with no back-pressure this gives one request per cycle.
REQ-018 SHALL advance PC by 4 on each accepted request, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL write each non-discarded IValid response into the buffer tail with the address of its request; the entry is visible on InstrValid the next cycle (1-cycle registered latency).
REQ-020 SHALL support a response and a consumption in the same cycle without loss or reordering.
REQ-021 SHALL, on Redirect=1: load PC with {Target[31:2],2'b00}, empty the buffer, and mark every in-flight request as stale; InstrValid=0 the following cycle.
REQ-022 SHALL silently drop stale responses (tracked with a stale-count register, 0..2) and never place them in the buffer.
REQ-023 SHALL give Redirect priority over consumption, response write and request issue in the same cycle; IReq=0 in the Redirect cycle.
REQ-024 SHALL resume requests from the new PC in the cycle after Redirect, even while stale responses are still outstanding, keeping total in-flight ≤ 2.
REQ-025 SHALL accept back-to-back Redirects; the last one sets PC.

Reset
REQ-026 SHALL, while nReset=0: PC=RESET_PC, buffer empty, in-flight and stale counts 0, IReq=0, InstrValid=0, Instruction=0, InstrAddrOut=0.
REQ-027 SHALL raise IReq with IAddr=RESET_PC in the first cycle after reset release.
REQ-028 SHALL discard, after a mid-operation reset, any response that arrives for a request issued before the reset.

Configuration
REQ-029 SHALL, when FETCH_PERF_EN is defined, add output FetchCount [31:0]: reset to 0, +1 on every consumption, wraps at 2^32, unaffected by Redirect.
REQ-030 SHALL, without FETCH_PERF_EN, have no FetchCount port and no counter logic; behaviour is otherwise identical.

Verification
REQ-031 SHALL cover: reset release, IReady=1, 1-cycle memory, DecStall=0 -> IAddr 0,4,8,...; InstrValid first high 2 cycles after the first request, one instruction per cycle.
REQ-032 SHALL cover: DecStall=1 for 5 cycles -> buffer fills to 2, IReq drops, head is held stable, and the order is intact after release.
REQ-033 SHALL cover: Redirect with Target=32'h0000_0103 while 2 requests are in flight -> both responses are dropped, next IAddr=32'h100, and the first delivered InstrAddrOut=32'h100.
REQ-034 SHALL cover: PC=32'hFFFF_FFFC accepted -> the next IAddr is 32'h0000_0000.
REQ-035 SHALL cover: nReset pulsed low while 2 requests are outstanding -> all outputs at reset values, the late responses are ignored, and fetch restarts at RESET_PC.
REQ-036 SHALL cover: with FETCH_PERF_EN, 10 consumptions including 1 Redirect -> FetchCount=10.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch with a 2-entry decode buffer; optional FetchCount counter under FETCH_PERF_EN.
// Latency: a response reaches InstrValid one cycle later; after Redirect, fetch restarts at Target the next cycle.
// Backpressure: IReq is withheld while in-flight plus buffered entries would exceed 2; DecStall holds the head.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        nReset,
    output logic [31:0] IAddr,
    output logic        IReq,
    input  logic        IReady,
    input  logic        IValid,
    input  logic [31:0] IData,
    input  logic        Redirect,
    input  logic [31:0] Target,
    input  logic        DecStall,
    output logic [31:0] Instruction,
    output logic [31:0] InstrAddrOut,
    output logic        InstrValid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount
`endif
);

    logic [31:0] pc;
    logic [1:0]  inflight;
    logic [1:0]  stale;
    logic [1:0]  count;
    logic [31:0] addr0, data0, addr1, data1;

    logic        consume;
    logic        resp;
    logic        push;
    logic        accept;
    logic [1:0]  live;
    logic [1:0]  wr_idx;
    logic [2:0]  used;
    logic [31:0] resp_addr;
    logic        unused_target_lsbs;

    assign IAddr        = pc;
    assign InstrValid   = (count != 2'd0);
    assign Instruction  = data0;
    assign InstrAddrOut = addr0;

    assign consume = InstrValid && !DecStall && !Redirect;
    // A response with nothing outstanding can only belong to a request issued before a reset.
    assign resp    = IValid && (inflight != 2'd0);
    assign push    = resp && (stale == 2'd0) && !Redirect;

    // The slot freed by this cycle's consumption is reusable at once, giving one request per cycle.
    assign used    = {1'b0, inflight} + {1'b0, count} - {2'b00, consume};
    assign IReq    = nReset && !Redirect && (used < 3'd2);
    assign accept  = IReq && IReady;

    // Live requests are contiguous and end just below pc, so the oldest one is pc - 4*live.
    assign live      = inflight - stale;
    assign resp_addr = pc - {28'd0, live, 2'b00};
    assign wr_idx    = count - {1'b0, consume};

    assign unused_target_lsbs = ^Target[1:0];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc       <= RESET_PC;
            inflight <= 2'd0;
            stale    <= 2'd0;
        end else if (Redirect) begin
            pc       <= {Target[31:2], 2'b00};
            inflight <= inflight - {1'b0, resp};
            stale    <= inflight - {1'b0, resp};
        end else begin
            if (accept) begin
                pc <= pc + 32'd4;
            end
            inflight <= inflight + {1'b0, accept} - {1'b0, resp};
            if (resp && (stale != 2'd0)) begin
                stale <= stale - 2'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count <= 2'd0;
            addr0 <= 32'd0;
            data0 <= 32'd0;
            addr1 <= 32'd0;
            data1 <= 32'd0;
        end else if (Redirect) begin
            count <= 2'd0;
        end else begin
            if (consume) begin
                addr0 <= addr1;
                data0 <= data1;
            end
            // Later assignment wins, so a write into slot 0 overrides the shift above.
            if (push) begin
                if (wr_idx == 2'd0) begin
                    addr0 <= resp_addr;
                    data0 <= IData;
                end else begin
                    addr1 <= resp_addr;
                    data1 <= IData;
                end
            end
            count <= count + {1'b0, push} - {1'b0, consume};
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            FetchCount <= 32'd0;
        end else if (consume) begin
            FetchCount <= FetchCount + 32'd1;
        end
    end
`endif

endmodule
